// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a 3-digit 7-segment driver.
// Holds a 12-bit hex value plus per-digit decimal points. Rotates digits
// 0 -> 1 -> 2 with a programmable on-time (SHOW). An optional blank gap
// (BLANK) follows each digit so the previous digit does not ghost into the
// next one.
//
// New values arrive over a valid/ready handshake. They are parked in a
// pending register and only become visible at a frame boundary, so a frame
// never mixes digits from two different values.
//
// Parameters
//   DIGIT_CYCLES  clock cycles per SHOW slot (>= 1)
//   BLANK_CYCLES  clock cycles per BLANK gap after each digit (0 = no gap)
//
// Optional feature (compile-time macro)
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are switched off
//                          during their SHOW slot (digit 2 if value[11:8]==0,
//                          digit 1 if value[11:4]==0). Digit 0 is always shown,
//                          and a digit with its decimal point set is never
//                          blanked. Slot timing is unchanged.
//
// Ports
//   clock          in   system clock, all logic on posedge
//   reset          in   synchronous, active-high
//   value_in       in   [11:8]=digit2, [7:4]=digit1, [3:0]=digit0
//   dp_mask_in     in   bit i lights the decimal point of digit i
//   load_valid     in   value_in / dp_mask_in valid
//   load_ready     out  controller can accept a load
//   display_en     in   0 = all digits off, scan parked at digit 0
//   digit_sel_out  out  driver digit select: 0..2 = digit, 3 = all off
//   nibble_out     out  driver nibble
//   dp_out         out  driver decimal point
//   frame_done     out  1-cycle pulse after each frame boundary
//
// All outputs are registered, so they reflect the FSM state of the
// previous cycle.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] value_in,
  input  logic [2:0]  dp_mask_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        display_en,
  output logic [1:0]  digit_sel_out,
  output logic [3:0]  nibble_out,
  output logic        dp_out,
  output logic        frame_done
);

  // The counter only has to reach the longer of the two slot lengths.
  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  // Unused when BLANK_CYCLES == 0; clamped so it never goes negative.
  localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit            HAS_GAP  = (BLANK_CYCLES > 0);

  localparam logic [1:0] SEL_OFF = 2'd3;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt, idx_inc;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wrap;          // this cycle is the last of the frame

  logic [11:0]   active_val, pending_val;
  logic [2:0]    active_dp, pending_dp;
  logic          pending_flag;

  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic          lz_blank;

  logic [1:0]    sel_nxt;
  logic [3:0]    nib_nxt;
  logic          dp_nxt;

  logic          accept, transfer;

  // ---------------------------------------------------------------------------
  // Digit mux: nibble and decimal point of the digit at idx.
  // ---------------------------------------------------------------------------
  always_comb begin : digit_mux
    cur_nib = active_val[3:0];
    cur_dp  = active_dp[0];
    case (idx)
      2'd1: begin
        cur_nib = active_val[7:4];
        cur_dp  = active_dp[1];
      end
      2'd2: begin
        cur_nib = active_val[11:8];
        cur_dp  = active_dp[2];
      end
      default: ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A lit decimal point keeps its digit visible even when it is a zero.
    lz_blank = ((idx == 2'd2) && (active_val[11:8] == 4'h0) && !active_dp[2]) ||
               ((idx == 2'd1) && (active_val[11:4] == 8'h00) && !active_dp[1]);
`else
    lz_blank = 1'b0;
`endif
  end

  assign idx_inc = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

  // ---------------------------------------------------------------------------
  // Scan FSM: next state and next output values.
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    sel_nxt   = SEL_OFF;
    nib_nxt   = nibble_out;  // nibble holds while no digit is selected
    dp_nxt    = 1'b0;

    if (!display_en) begin
      // Parked at the start of digit 0 so re-enable begins a clean frame.
      state_nxt = SHOW;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        SHOW: begin
          nib_nxt = cur_nib;
          if (!lz_blank) begin
            sel_nxt = idx;
            dp_nxt  = cur_dp;
          end
          if (cnt == DIG_LAST) begin
            cnt_nxt = '0;
            if (HAS_GAP) begin
              state_nxt = BLANK;
            end else begin
              // No gap: the SHOW slot of digit 2 itself closes the frame.
              idx_nxt = idx_inc;
              wrap    = (idx == 2'd2);
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLK_LAST) begin
            cnt_nxt   = '0;
            state_nxt = SHOW;
            idx_nxt   = idx_inc;
            wrap      = (idx == 2'd2);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = SHOW;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // load_ready is kept equal to !pending_flag, so a load can never be
  // accepted in the same cycle that the pending value moves to active.
  assign accept   = load_valid & load_ready;
  assign transfer = pending_flag & (wrap | ~display_en);

  // ---------------------------------------------------------------------------
  // State, output and value registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= SHOW;
      idx           <= 2'd0;
      cnt           <= '0;
      digit_sel_out <= SEL_OFF;
      nibble_out    <= 4'h0;
      dp_out        <= 1'b0;
      frame_done    <= 1'b0;
      active_val    <= 12'h000;
      active_dp     <= 3'b000;
      pending_val   <= 12'h000;
      pending_dp    <= 3'b000;
      pending_flag  <= 1'b0;
      load_ready    <= 1'b1;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      digit_sel_out <= sel_nxt;
      nibble_out    <= nib_nxt;
      dp_out        <= dp_nxt;
      frame_done    <= wrap;

      if (transfer) begin
        active_val   <= pending_val;
        active_dp    <= pending_dp;
        pending_flag <= 1'b0;
        load_ready   <= 1'b1;
      end
      if (accept) begin
        pending_val  <= value_in;
        pending_dp   <= dp_mask_in;
        pending_flag <= 1'b1;
        load_ready   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int D     = 4;
  localparam int B     = 2;
  localparam int SLOT  = D + B;
  localparam int FRAME = 3 * SLOT;

  logic        clk;
  logic        rst;
  logic [11:0] value;
  logic [2:0]  dpm;
  logic        lv;
  logic        en;
  logic        ready;
  logic [1:0]  sel;
  logic [3:0]  nib;
  logic        dp;
  logic        fd;

  // Second instance without a blank gap.
  logic [11:0] value0;
  logic [2:0]  dpm0;
  logic        lv0;
  logic        en0;
  logic        ready0;
  logic [1:0]  sel0;
  logic [3:0]  nib0;
  logic        dp0;
  logic        fd0;

  int n_chk;
  int n_fail;

  display_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clock(clk), .reset(rst), .value_in(value), .dp_mask_in(dpm),
    .load_valid(lv), .load_ready(ready), .display_en(en),
    .digit_sel_out(sel), .nibble_out(nib), .dp_out(dp), .frame_done(fd)
  );

  display_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0)) dut0 (
    .clock(clk), .reset(rst), .value_in(value0), .dp_mask_in(dpm0),
    .load_valid(lv0), .load_ready(ready0), .display_en(en0),
    .digit_sel_out(sel0), .nibble_out(nib0), .dp_out(dp0), .frame_done(fd0)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. It tracks the position m_t inside the frame and derives
  // the slot and the show/blank phase arithmetically from that position.
  // ---------------------------------------------------------------------------
  int          m_t;
  logic [11:0] m_act, m_pend;
  logic [2:0]  m_dpm, m_pdpm;
  bit          m_pflag;
  logic [1:0]  e_sel;
  logic [3:0]  e_nib;
  logic        e_dp, e_fd, e_ready;

  function automatic logic [3:0] digit_of(logic [11:0] v, int s);
    return 4'((v >> (4 * s)) & 12'h00F);
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  function automatic bit lz_off(logic [11:0] v, logic [2:0] m, int s);
    if (s == 2) return (v[11:8] == 4'h0) && !m[2];
    if (s == 1) return (v[11:4] == 8'h00) && !m[1];
    return 1'b0;
  endfunction
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_t <= 0; m_act <= '0; m_dpm <= '0; m_pend <= '0; m_pdpm <= '0; m_pflag <= 0;
      e_sel <= 2'd3; e_nib <= 4'h0; e_dp <= 1'b0; e_fd <= 1'b0; e_ready <= 1'b1;
    end else begin
      if (!en) begin
        e_sel <= 2'd3; e_dp <= 1'b0; e_fd <= 1'b0; m_t <= 0;
      end else begin
        if ((m_t % SLOT) < D) begin
`ifdef LEADING_ZERO_BLANK_EN
          e_sel <= lz_off(m_act, m_dpm, m_t / SLOT) ? 2'd3 : 2'(m_t / SLOT);
`else
          e_sel <= 2'(m_t / SLOT);
`endif
          e_nib <= digit_of(m_act, m_t / SLOT);
          e_dp  <= m_dpm[m_t / SLOT];
        end else begin
          e_sel <= 2'd3; e_dp <= 1'b0;
        end
        e_fd <= (m_t == FRAME - 1);
        m_t  <= (m_t == FRAME - 1) ? 0 : m_t + 1;
      end
      if (m_pflag && (!en || m_t == FRAME - 1)) begin
        m_act <= m_pend; m_dpm <= m_pdpm; m_pflag <= 0; e_ready <= 1'b1;
      end
      if (lv && e_ready) begin
        m_pend <= value; m_pdpm <= dpm; m_pflag <= 1; e_ready <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [1:0] seq [8];
    seq = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
    rst = 1; lv = 1; value = 12'hFFF; dpm = 3'b111; en = 1;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (sel !== 2'd3 || ready !== 1'b1 || fd !== 1'b0 || nib !== 4'h0 || dp !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got sel=%0d ready=%b fd=%b nib=%h dp=%b, want sel=3 ready=1 fd=0 nib=0 dp=0",
                 sel, ready, fd, nib, dp);
      end
    end
    rst = 0; lv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++;
      if (sel !== seq[i] || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_seq[%0d]: got sel=%0d ready=%b, want sel=%0d ready=1", i, sel, ready, seq[i]);
      end
    end
  endtask

  task automatic test_load_basic();
    logic [3:0] tn [3];
    bit         tdp [3];
    int         last;
    bit         applied;
    tn = '{4'hC, 4'h5, 4'hA};
    tdp = '{1'b0, 1'b1, 1'b0};
    last = -1; applied = 0;
    lv = 1; value = 12'hA5C; dpm = 3'b010;
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      if (c == 0) lv = 0;
      n_chk++;
      if ({sel, nib, dp, fd, ready} !== {e_sel, e_nib, e_dp, e_fd, e_ready}) begin
        n_fail++;
        $display("FAIL load_basic_model c=%0d: got sel=%0d nib=%h dp=%b fd=%b rdy=%b, want sel=%0d nib=%h dp=%b fd=%b rdy=%b",
                 c, sel, nib, dp, fd, ready, e_sel, e_nib, e_dp, e_fd, e_ready);
      end
      if (fd) begin
        if (last >= 0) begin
          n_chk++;
          if (c - last != FRAME) begin
            n_fail++;
            $display("FAIL frame_period: got %0d cycles, want %0d", c - last, FRAME);
          end
        end
        last = c; applied = 1;
      end else if (applied && sel != 2'd3) begin
        n_chk++;
        if (nib !== tn[sel] || dp !== tdp[sel]) begin
          n_fail++;
          $display("FAIL load_basic_digit sel=%0d: got nib=%h dp=%b, want nib=%h dp=%b", sel, nib, dp, tn[sel], tdp[sel]);
        end
      end
    end
    n_chk++;
    if (last < 0) begin
      n_fail++;
      $display("FAIL load_basic_frame_done: got no pulse, want pulses every %0d", FRAME);
    end
  endtask

  task automatic test_midframe();
    bit         seen;
    logic [3:0] want_nib;
    logic       want_dp;
    int         k;
    k = 0;
    while (!fd && k < 3 * FRAME) begin @(negedge clk); k++; end
    n_chk++;
    if (!fd) begin n_fail++; $display("FAIL midframe_wait: got no frame_done, want one within %0d cycles", 3 * FRAME); end
    repeat (7) @(negedge clk);
    lv = 1; value = 12'h123; dpm = 3'b000;
    seen = 0;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      @(negedge clk);
      if (c == 0) begin value = 12'hFFF; dpm = 3'b111; end
      if (c == 3) lv = 0;
      if (fd) seen = 1;
      n_chk++;
      if ({sel, nib, dp, fd, ready} !== {e_sel, e_nib, e_dp, e_fd, e_ready}) begin
        n_fail++;
        $display("FAIL midframe_model c=%0d: got sel=%0d nib=%h dp=%b fd=%b rdy=%b, want sel=%0d nib=%h dp=%b fd=%b rdy=%b",
                 c, sel, nib, dp, fd, ready, e_sel, e_nib, e_dp, e_fd, e_ready);
      end
      n_chk++;
      if (ready !== seen) begin
        n_fail++;
        $display("FAIL midframe_ready c=%0d: got %b, want %b", c, ready, seen);
      end
      if (sel != 2'd3) begin
        want_nib = seen ? digit_of(12'h123, int'(sel)) : digit_of(12'hA5C, int'(sel));
        want_dp  = seen ? 1'b0 : (sel == 2'd1);
        n_chk++;
        if (nib !== want_nib || dp !== want_dp) begin
          n_fail++;
          $display("FAIL midframe_digit c=%0d sel=%0d: got nib=%h dp=%b, want nib=%h dp=%b", c, sel, nib, dp, want_nib, want_dp);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [1:0] seq [6];
    int         k;
    seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
    k = 0;
    while (sel != 2'd1 && k < 3 * FRAME) begin @(negedge clk); k++; end
    n_chk++;
    if (sel != 2'd1) begin n_fail++; $display("FAIL disable_wait: got sel=%0d, want 1", sel); end
    en = 0; lv = 1; value = 12'h3B7; dpm = 3'b000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) lv = 0;
      n_chk++;
      if (sel !== 2'd3 || fd !== 1'b0 || dp !== 1'b0 ||
          {nib, ready} !== {e_nib, e_ready}) begin
        n_fail++;
        $display("FAIL disable_off c=%0d: got sel=%0d fd=%b dp=%b nib=%h rdy=%b, want sel=3 fd=0 dp=0 nib=%h rdy=%b",
                 c, sel, fd, dp, nib, ready, e_nib, e_ready);
      end
    end
    en = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if (sel !== seq[c] || (seq[c] == 2'd0 && nib !== 4'h7) ||
          {sel, nib, dp, fd, ready} !== {e_sel, e_nib, e_dp, e_fd, e_ready}) begin
        n_fail++;
        $display("FAIL reenable c=%0d: got sel=%0d nib=%h dp=%b fd=%b rdy=%b, want sel=%0d nib=%h dp=%b fd=%b rdy=%b",
                 c, sel, nib, dp, fd, ready, seq[c], e_nib, e_dp, e_fd, e_ready);
      end
    end
  endtask

  task automatic test_lzb();
    logic [11:0] cv [3];
    logic [2:0]  cd [3];
    int          want2 [3];
    int          want1 [3];
    int          n0, n1, n2, k;
    cv = '{12'h007, 12'h000, 12'h007};
    cd = '{3'b000, 3'b000, 3'b100};
`ifdef LEADING_ZERO_BLANK_EN
    want2 = '{0, 0, D}; want1 = '{0, 0, 0};
`else
    want2 = '{D, D, D}; want1 = '{D, D, D};
`endif
    for (int t = 0; t < 3; t++) begin
      lv = 1; value = cv[t]; dpm = cd[t];
      @(negedge clk);
      lv = 0;
      k = 0;
      do begin @(negedge clk); k++; end while (!fd && k < 3 * FRAME);
      n_chk++;
      if (!fd) begin n_fail++; $display("FAIL lzb_wait[%0d]: got no frame_done, want one", t); end
      n0 = 0; n1 = 0; n2 = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        n_chk++;
        if ({sel, nib, dp, fd, ready} !== {e_sel, e_nib, e_dp, e_fd, e_ready}) begin
          n_fail++;
          $display("FAIL lzb_model[%0d] c=%0d: got sel=%0d nib=%h dp=%b fd=%b rdy=%b, want sel=%0d nib=%h dp=%b fd=%b rdy=%b",
                   t, c, sel, nib, dp, fd, ready, e_sel, e_nib, e_dp, e_fd, e_ready);
        end
        if (sel == 2'd0) begin
          n0++;
          n_chk++;
          if (nib !== cv[t][3:0]) begin
            n_fail++;
            $display("FAIL lzb_digit0[%0d]: got nib=%h, want %h", t, nib, cv[t][3:0]);
          end
        end
        if (sel == 2'd1) n1++;
        if (sel == 2'd2) begin
          n2++;
          n_chk++;
          if (nib !== 4'h0 || dp !== cd[t][2]) begin
            n_fail++;
            $display("FAIL lzb_digit2[%0d]: got nib=%h dp=%b, want nib=0 dp=%b", t, nib, dp, cd[t][2]);
          end
        end
      end
      n_chk++;
      if (n0 != D || n1 != want1[t] || n2 != want2[t]) begin
        n_fail++;
        $display("FAIL lzb_slots[%0d]: got d0=%0d d1=%0d d2=%0d cycles, want d0=%0d d1=%0d d2=%0d",
                 t, n0, n1, n2, D, want1[t], want2[t]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_chk++;
      if ({sel, nib, dp, fd, ready} !== {e_sel, e_nib, e_dp, e_fd, e_ready}) begin
        n_fail++;
        $display("FAIL random_model c=%0d: got sel=%0d nib=%h dp=%b fd=%b rdy=%b, want sel=%0d nib=%h dp=%b fd=%b rdy=%b",
                 c, sel, nib, dp, fd, ready, e_sel, e_nib, e_dp, e_fd, e_ready);
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      lv    = ($urandom_range(0, 7) == 0);
      value = 12'($urandom_range(0, 4095));
      dpm   = 3'($urandom_range(0, 7));
    end
    en = 1; lv = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_blank();
    int k;
    k = 0;
    while (!fd0 && k < 40) begin @(negedge clk); k++; end
    n_chk++;
    if (!fd0) begin n_fail++; $display("FAIL no_blank_wait: got no frame_done, want one within 40 cycles"); end
    for (int i = 1; i <= 3 * D; i++) begin
      @(negedge clk);
      n_chk++;
      if (sel0 !== 2'((i - 1) / D) || fd0 !== (i == 3 * D) ||
          nib0 !== 4'h0 || dp0 !== 1'b0 || ready0 !== 1'b1) begin
        n_fail++;
        $display("FAIL no_blank i=%0d: got sel=%0d fd=%b nib=%h dp=%b rdy=%b, want sel=%0d fd=%b nib=0 dp=0 rdy=1",
                 i, sel0, fd0, nib0, dp0, ready0, (i - 1) / D, (i == 3 * D));
      end
    end
  endtask

  initial begin
    clk = 0; rst = 1; en = 1; lv = 0; value = '0; dpm = '0;
    value0 = '0; dpm0 = '0; lv0 = 0; en0 = 1;
    n_chk = 0; n_fail = 0;
    test_reset();
    test_load_basic();
    test_midframe();
    test_disable();
    test_lzb();
    test_random();
    test_no_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
